// File: rtl/mem_arbiter.sv
// Byte-serialising arbiter sharing one synchronous RAM port between IF (4-byte reads) and LS (1/2/4-byte loads/stores).
// Optional build macro MEM_ARB_IO_STALL_EN adds in_io_buffer_full, which stalls store bytes aimed at 0x30000-0x3FFFF.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  in_rollback,
    input  logic                  in_if_ena,
    input  logic [ADDR_WIDTH-1:0] in_if_addr,
    output logic                  out_if_ready,
    output logic [DATA_WIDTH-1:0] out_if_data,
    input  logic                  in_ls_ena,
    input  logic                  in_ls_iswrite,
    input  logic [ADDR_WIDTH-1:0] in_ls_addr,
    input  logic [DATA_WIDTH-1:0] in_ls_write_data,
    input  logic [2:0]            in_ls_size,
    output logic                  out_ls_ready,
    output logic [DATA_WIDTH-1:0] out_ls_read_data,
`ifdef MEM_ARB_IO_STALL_EN
    input  logic                  in_io_buffer_full,
`endif
    input  logic [7:0]            in_ram_data,
    output logic [ADDR_WIDTH-1:0] out_ram_addr,
    output logic [7:0]            out_ram_data,
    output logic                  out_ram_wr
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN} state_t;

    state_t                state_q;
    logic                  if_pend_q, ls_pend_q;
    logic [ADDR_WIDTH-1:0] if_addr_q, ls_addr_q;
    logic [DATA_WIDTH-1:0] ls_wdata_q;
    logic                  ls_write_q;
    logic [1:0]            ls_nm1_q;

    logic                  sel_ls_q, write_q, hold_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [1:0]            nm1_q, idx_q;

    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [7:0]            ram_data_q;
    logic                  ram_wr_q;
    logic                  if_ready_q, ls_ready_q;
    logic [DATA_WIDTH-1:0] if_data_q, ls_data_q;

    logic [1:0]            nxt_idx_d, cap_lane_d;
    logic [ADDR_WIDTH-1:0] pres_addr_d;
    logic                  pres_write_d, stall_d, if_busy_d, ls_busy_d, last_d;
    logic [DATA_WIDTH-1:0] src_wdata_d, rdata_fin_d;
    logic [7:0]            wbyte_d;

    function automatic logic [1:0] size_nm1(input logic [2:0] sz);
        case (sz)
            3'd1:    return 2'd0;
            3'd2:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Next byte to put on the RAM port: byte 0 of the winner when idle, else the following byte of the transfer.
    always_comb begin
        if_busy_d  = (state_q != S_IDLE) && !sel_ls_q;
        ls_busy_d  = (state_q != S_IDLE) && sel_ls_q;
        last_d     = (idx_q == nm1_q);
        cap_lane_d = idx_q - 2'd1;
        if (state_q == S_IDLE) begin
            nxt_idx_d    = 2'd0;
            pres_addr_d  = ls_pend_q ? ls_addr_q : if_addr_q;
            pres_write_d = ls_pend_q && ls_write_q;
            src_wdata_d  = ls_wdata_q;
        end else begin
            nxt_idx_d    = hold_q ? idx_q : idx_q + 2'd1;
            pres_addr_d  = base_q + ADDR_WIDTH'(nxt_idx_d);
            pres_write_d = write_q;
            src_wdata_d  = wdata_q;
        end
        wbyte_d = 8'h00;
        for (int b = 0; b < 4; b++) begin
            if (nxt_idx_d == 2'(b)) wbyte_d = src_wdata_d[8*b +: 8];
        end
        rdata_fin_d = rdata_q;
        for (int b = 0; b < 4; b++) begin
            if (idx_q == 2'(b)) rdata_fin_d[8*b +: 8] = in_ram_data;
        end
    end

`ifdef MEM_ARB_IO_STALL_EN
    assign stall_d = in_io_buffer_full && pres_write_d &&
                     (pres_addr_d >= ADDR_WIDTH'(32'h0003_0000)) &&
                     (pres_addr_d <= ADDR_WIDTH'(32'h0003_FFFF));
`else
    assign stall_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            if_pend_q  <= 1'b0;
            ls_pend_q  <= 1'b0;
            if_addr_q  <= '0;
            ls_addr_q  <= '0;
            ls_wdata_q <= '0;
            ls_write_q <= 1'b0;
            ls_nm1_q   <= 2'd0;
            sel_ls_q   <= 1'b0;
            write_q    <= 1'b0;
            hold_q     <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            nm1_q      <= 2'd0;
            idx_q      <= 2'd0;
            ram_addr_q <= '0;
            ram_data_q <= 8'h00;
            ram_wr_q   <= 1'b0;
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
            if_data_q  <= '0;
            ls_data_q  <= '0;
        end else if (ena) begin
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
            if_data_q  <= '0;
            ls_data_q  <= '0;

            if (in_if_ena && !if_pend_q && !if_busy_d && !in_rollback) begin
                if_pend_q <= 1'b1;
                if_addr_q <= in_if_addr;
            end
            if (in_rollback) if_pend_q <= 1'b0;
            if (in_ls_ena && !ls_pend_q && !ls_busy_d) begin
                ls_pend_q  <= 1'b1;
                ls_addr_q  <= in_ls_addr;
                ls_wdata_q <= in_ls_write_data;
                ls_write_q <= in_ls_iswrite;
                ls_nm1_q   <= size_nm1(in_ls_size);
            end

            case (state_q)
                S_IDLE: begin
                    if (ls_pend_q || (if_pend_q && !in_rollback)) begin
                        sel_ls_q   <= ls_pend_q;
                        base_q     <= pres_addr_d;
                        write_q    <= pres_write_d;
                        wdata_q    <= ls_wdata_q;
                        nm1_q      <= ls_pend_q ? ls_nm1_q : 2'd3;
                        idx_q      <= 2'd0;
                        rdata_q    <= '0;
                        ram_addr_q <= pres_addr_d;
                        hold_q     <= stall_d;
                        ram_wr_q   <= pres_write_d && !stall_d;
                        ram_data_q <= (pres_write_d && !stall_d) ? wbyte_d : 8'h00;
                        state_q    <= S_XFER;
                        if (ls_pend_q) ls_pend_q <= 1'b0;
                        else           if_pend_q <= 1'b0;
                    end
                end
                S_XFER: begin
                    if (!sel_ls_q && in_rollback) begin
                        ram_wr_q   <= 1'b0;
                        ram_data_q <= 8'h00;
                        state_q    <= S_IDLE;
                    end else begin
                        // Byte idx-1 was presented last cycle, so its read data is on in_ram_data now.
                        if (!write_q && idx_q != 2'd0) begin
                            for (int b = 0; b < 4; b++) begin
                                if (cap_lane_d == 2'(b)) rdata_q[8*b +: 8] <= in_ram_data;
                            end
                        end
                        if (!hold_q && last_d) begin
                            ram_wr_q   <= 1'b0;
                            ram_data_q <= 8'h00;
                            if (write_q) begin
                                ls_ready_q <= 1'b1;
                                state_q    <= S_IDLE;
                            end else begin
                                state_q    <= S_DRAIN;
                            end
                        end else begin
                            idx_q      <= nxt_idx_d;
                            ram_addr_q <= pres_addr_d;
                            hold_q     <= stall_d;
                            ram_wr_q   <= write_q && !stall_d;
                            ram_data_q <= (write_q && !stall_d) ? wbyte_d : 8'h00;
                        end
                    end
                end
                S_DRAIN: begin
                    state_q <= S_IDLE;
                    if (sel_ls_q) begin
                        ls_ready_q <= 1'b1;
                        ls_data_q  <= rdata_fin_d;
                    end else if (!in_rollback) begin
                        if_ready_q <= 1'b1;
                        if_data_q  <= rdata_fin_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_ram_addr     = ram_addr_q;
    assign out_ram_data     = ram_data_q;
    assign out_ram_wr       = ram_wr_q;
    assign out_if_ready     = if_ready_q;
    assign out_if_data      = if_data_q;
    assign out_ls_ready     = ls_ready_q;
    assign out_ls_read_data = ls_data_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide synchronous RAM port between instruction fetch (IF) and the load/store queue (LS).
- Accepts single-cycle request pulses from both requesters and arbitrates between them.
- Splits each 1/2/4-byte access into consecutive byte cycles and returns one ready pulse per request.
- Sits between ifetch/LSqueue and the RAM/IO bus at the top level.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, requester data width; must be a multiple of 8.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- ena  input  1  global enable; low freezes all state
- in_rollback  input  1  misbranch flush; affects IF only
- in_if_ena  input  1  IF request pulse (4-byte read)
- in_if_addr  input  ADDR_WIDTH  IF address
- out_if_ready  output  1  IF done pulse
- out_if_data  output  DATA_WIDTH  fetched word, valid with out_if_ready
- in_ls_ena  input  1  LS request pulse
- in_ls_iswrite  input  1  1 = store
- in_ls_addr  input  ADDR_WIDTH  LS address
- in_ls_write_data  input  DATA_WIDTH  store data
- in_ls_size  input  3  byte count: 1, 2 or 4
- out_ls_ready  output  1  LS done pulse
- out_ls_read_data  output  DATA_WIDTH  load data, zero-extended, valid with out_ls_ready
- in_ram_data  input  8  RAM read byte
- out_ram_addr  output  ADDR_WIDTH  RAM byte address
- out_ram_data  output  8  RAM write byte
- out_ram_wr  output  1  RAM write strobe

Behaviour:
- Reset: every output is 0; both pending flags clear; state IDLE.
- Reset is honoured mid-transfer: the access is dropped and no ready pulse is produced.
- Request capture: a request pulse sampled at a clock edge sets that port's pending flag and latches its address/data/size.
- A pulse on a port that is already pending or in flight is ignored (protocol violation).
- Size encoding: 1 or 2 bytes as given; any other value is treated as 4. IF is always 4 bytes.
- States:
  - IDLE: on the edge after a pending flag is seen, grant it, clear its flag, present byte 0, go to XFER with idx=0. If both ports are pending, LS wins.
  - XFER: present out_ram_addr = base+idx and increment idx each cycle through idx = N-1.
    - Store: out_ram_wr=1 and out_ram_data = data[8idx+7:8idx].
    - Read: out_ram_wr=0.
    - After the last byte: a store pulses ready on the next edge and returns to IDLE; a read goes to DRAIN.
  - DRAIN: the read byte for address k arrives on in_ram_data in the cycle after k was presented and is captured into bits [8k+7:8k]. The final byte is captured and ready pulses on the same edge; return to IDLE.
- Latency, counted from the request-sampling edge E0 with the arbiter idle:
  - N-byte store: ready is high in the cycle after edge E(N+1).
  - N-byte read: ready is high in the cycle after edge E(N+2).
- Unused upper read bits are 0; sign extension is the requester's job.
- Ready and data outputs are 1-cycle pulses; data returns to 0 the next cycle.
- out_ram_wr is never high outside XFER-store cycles.
- A request arriving while the other port is served is latched and granted in the IDLE cycle that follows.
- Back-to-back grants: there is always one IDLE cycle between transfers.
- in_rollback (when ena high):
  - Clears the IF pending flag.
  - Aborts an in-flight IF read: return to IDLE with no out_if_ready.
  - LS pending or in-flight accesses are unaffected and complete normally, because committed stores and issued loads must finish.
  - A simultaneous in_if_ena is discarded.
- ena low: all registers hold, including out_ram_addr and out_ram_wr; request pulses are not sampled.

Optional Feature:
- Macro: MEM_ARB_IO_STALL_EN.
- With the macro:
  - Adds input in_io_buffer_full (1 bit).
  - While it is high, an XFER store byte whose address lies in 0x30000–0x3FFFF is not presented: out_ram_wr=0, idx holds, state holds.
  - The byte proceeds in the first cycle the input is low, so the latency grows by the stall cycles.
- Without the macro: the port is absent and IO addresses are treated like any RAM address.

Test Plan:
- LS load size 4 at 0x100, RAM holding 0x11,0x22,0x33,0x44 -> out_ls_ready pulses 6 edges after the request edge with out_ls_read_data=0x44332211; out_ram_wr stays 0.
- LS store size 2, addr 0x200, data 0xAABBCCDD -> out_ram_wr=1 at 0x200 with 0xDD, then 0x201 with 0xCC; ready 3 edges after the request edge; 0x202 is never written.
- IF and LS pulses on the same edge -> LS is served first; IF is granted after the LS ready plus one IDLE cycle; IF data is correct.
- IF read in flight, in_rollback at idx=2 -> no out_if_ready; next cycle is IDLE; a later IF request works normally.
- LS load size 1 with rollback during the transfer -> completes; out_ls_read_data = 0x000000XX; ready is delivered.
- rst asserted mid-store and ena held low for 3 cycles mid-read -> after reset all outputs are 0 with no ready; with ena low out_ram_addr holds and ready is delayed by exactly 3 cycles.
